crono_timer: RTL and testbench
==============================

CRONO_TIMER -- requirements
Module: crono_timer

Interface
REQ-001 SHALL have parameter TICKS, default 100000000, meaning CLK cycles per one-second count step.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; begin or resume counting.
REQ-005 SHALL have port stop  input  1  one-cycle pulse; pause counting.
REQ-006 SHALL have port clear  input  1  one-cycle pulse; zero the count and return to IDLE.
REQ-007 SHALL have port prog_en  input  1  target-edit mode; level signal.
REQ-008 SHALL have port dir_cursor  input  3  selected target digit: 1=h tens, 2=h units, 3=m tens, 4=m units, 5=s tens, 6=s units; 0 and 7 select none.
REQ-009 SHALL have port inc  input  1  one-cycle pulse; increment the selected target digit.
REQ-010 SHALL have port dec  input  1  one-cycle pulse; decrement the selected target digit.
REQ-011 SHALL have outputs hcrono, mcrono, scrono  output  8 each  elapsed time, packed BCD {tens,units}.
REQ-012 SHALL have outputs hcrono_fin, mcrono_fin, scrono_fin  output  8 each  target time, packed BCD.
REQ-013 SHALL have port fin_crono  output  1  one-cycle pulse when the elapsed time reaches the target.
REQ-014 SHALL have port running  output  1  high while in state RUN.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN, PAUSE and DONE.
REQ-016 SHALL make these transitions: IDLE -start-> RUN; RUN -stop-> PAUSE; PAUSE -start-> RUN; RUN -match-> DONE; any state -clear-> IDLE.
REQ-017 SHALL apply input priority clear > stop > start; inc and dec arriving in the same cycle SHALL both be ignored.
REQ-018 SHALL ignore start in IDLE when the target is 00:00:00, and SHALL ignore start in DONE.
REQ-019 SHALL reset the prescaler to 0 when start is accepted, so the first increment occurs exactly TICKS cycles after start.
REQ-020 SHALL assert running in the cycle after start is accepted.
REQ-021 SHALL run the prescaler only in RUN and SHALL hold its value in PAUSE.
REQ-022 SHALL advance the elapsed time by one second per prescaler wrap, in BCD: seconds 00-59 and minutes 00-59 with carry, hours 00-23 wrapping to 00.
REQ-023 SHALL give stop precedence over a tick in the same cycle: no increment occurs.
REQ-024 SHALL, when an increment makes the elapsed time equal the target, pulse fin_crono for exactly one cycle (the cycle after the increment), enter DONE and hold the count.
REQ-025 SHALL apply target edits only while prog_en=1 and state is IDLE or PAUSE; otherwise inc/dec SHALL be ignored.
REQ-026 SHALL wrap the target digits as follows: seconds and minutes tens 0-5; all units 0-9, except hour units 0-3 when hour tens=2; hour tens 0-2.
REQ-027 SHALL force hour units to 3 when hour tens becomes 2 while hour units >3.
REQ-028 SHALL, on clear, zero the elapsed time and prescaler and retain the target.
REQ-029 SHALL keep all BCD outputs valid BCD in every cycle; no nibble SHALL exceed 9.

Reset
REQ-030 SHALL, on rst=0, immediately force: state IDLE, elapsed time and target 00:00:00, prescaler 0, fin_crono=0, running=0.
REQ-031 SHALL abandon any count in progress when reset asserts mid-run; counting SHALL NOT resume after release.
REQ-032 SHALL synchronously release all internal state into IDLE on the first CLK edge after rst deasserts.

Structure
REQ-033 SHALL place the state encoding, digit-limit constants (5, 9, 2, 3) and the cursor codes in the shared project package.
REQ-034 SHALL use one sub-module, bcd_mod_counter: a single BCD digit with programmable limit, inc/dec, wrap and carry-out, instantiated for the time digits.

Verification (TICKS=4)
REQ-035 SHALL verify: target 00:00:03, start -> running next cycle; scrono 01, 02, 03 at cycles 4, 8, 12 after start; fin_crono single pulse at cycle 13; state DONE, count held.
REQ-036 SHALL verify: preload 00:00:59 internally, target 00:02:00, run 4 cycles -> 00:01:00 with correct carry; and 23:59:59 + 1 -> 00:00:00.
REQ-037 SHALL verify: stop in the same cycle as a tick -> no increment; start 10 cycles later -> next increment exactly 4 cycles later.
REQ-038 SHALL verify: prog_en=1, cursor=2, hour tens=2, 5x inc -> hour units 1,2,3,0,1; cursor=1 with hour units=9, inc to 2 -> hcrono_fin=8'h23.
REQ-039 SHALL verify: rst=0 for 1 cycle mid-run at 00:00:02 -> all outputs zero immediately; no fin_crono follows.
REQ-040 SHALL verify: clear and start in the same cycle while RUN -> IDLE, count 00:00:00, running=0.

Source files
------------

// File: rtl/crono_timer_pkg.sv
// Shared definitions for the crono_timer stopwatch: FSM encoding, BCD digit limits,
// target cursor codes and the single-digit BCD step helper.
package crono_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } crono_state_t;

    localparam logic [3:0] LIM_TENS        = 4'd5;
    localparam logic [3:0] LIM_UNITS       = 4'd9;
    localparam logic [3:0] LIM_HTENS       = 4'd2;
    localparam logic [3:0] LIM_HUNITS_TOP  = 4'd3;

    localparam logic [2:0] CUR_H_TENS  = 3'd1;
    localparam logic [2:0] CUR_H_UNITS = 3'd2;
    localparam logic [2:0] CUR_M_TENS  = 3'd3;
    localparam logic [2:0] CUR_M_UNITS = 3'd4;
    localparam logic [2:0] CUR_S_TENS  = 3'd5;
    localparam logic [2:0] CUR_S_UNITS = 3'd6;

    // One wrap-around step of a BCD digit bounded by lim; out-of-range values snap back in range.
    function automatic logic [3:0] bcd_step(input logic [3:0] v, input logic [3:0] lim, input logic up);
        logic [3:0] r;
        if (up) begin
            r = (v >= lim) ? 4'd0 : v + 4'd1;
        end else begin
            r = ((v == 4'd0) || (v > lim)) ? lim : v - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/crono_timer_bcd_mod_counter.sv
// Single BCD digit with programmable upper limit, inc/dec with wrap, and a carry-out
// that fires when an increment wraps the digit back to zero.
module bcd_mod_counter
    import crono_timer_pkg::*;
(
    input  logic       CLK,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    input  logic [3:0] limit,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_r;

    // Digit register: sync clear, then a single step when exactly one of inc/dec is set.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            q_r <= 4'd0;
        end else if (clr) begin
            q_r <= 4'd0;
        end else if (inc ^ dec) begin
            q_r <= bcd_step(q_r, limit, inc);
        end else begin
            q_r <= q_r;
        end
    end

    assign q     = q_r;
    assign carry = inc && !dec && (q_r >= limit);

endmodule

// File: rtl/crono_timer.sv
// Stopwatch counting HH:MM:SS in BCD up to a programmable target, with
// start/stop/clear control and a one-cycle fin_crono pulse on reaching the target.
module crono_timer
    import crono_timer_pkg::*;
#(
    parameter int TICKS = 100000000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       prog_en,
    input  logic [2:0] dir_cursor,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] hcrono,
    output logic [7:0] mcrono,
    output logic [7:0] scrono,
    output logic [7:0] hcrono_fin,
    output logic [7:0] mcrono_fin,
    output logic [7:0] scrono_fin,
    output logic       fin_crono,
    output logic       running
);

    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS - 1);

    crono_state_t  state_r;
    logic [PW-1:0] presc_r;
    logic          fin_r;
    logic          running_r;
    logic          inc_done_r;

    logic [3:0] tgt_ht_r, tgt_hu_r, tgt_mt_r, tgt_mu_r, tgt_st_r, tgt_su_r;
    logic [3:0] e_ht_s, e_hu_s, e_mt_s, e_mu_s, e_st_s, e_su_s;
    logic       c_su_s, c_st_s, c_mu_s, c_mt_s, c_hu_s, ht_carry_unused_s;
    logic [3:0] e_hu_lim_s;

    logic       start_ok_s, match_s, tick_s, tgt_nonzero_s, elapsed_eq_s, edit_en_s;
    logic [3:0] sel_val_s, sel_lim_s, edit_nxt_s, tgt_hu_lim_s;

    assign tgt_nonzero_s = |{tgt_ht_r, tgt_hu_r, tgt_mt_r, tgt_mu_r, tgt_st_r, tgt_su_r};
    assign elapsed_eq_s  = ({hcrono, mcrono, scrono} == {hcrono_fin, mcrono_fin, scrono_fin});
    assign start_ok_s    = start && (((state_r == ST_IDLE) && tgt_nonzero_s) || (state_r == ST_PAUSE));
    // The match is judged the cycle after the increment, so fin_crono lags the new count by one.
    assign match_s       = inc_done_r && elapsed_eq_s && (state_r == ST_RUN);
    assign tick_s        = !clear && !match_s && !stop && (state_r == ST_RUN) && (presc_r == PRESC_LAST);

    // Control FSM with prescaler; outputs fin_crono and running are registered here.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            presc_r    <= '0;
            fin_r      <= 1'b0;
            running_r  <= 1'b0;
            inc_done_r <= 1'b0;
        end else if (clear) begin
            state_r    <= ST_IDLE;
            presc_r    <= '0;
            fin_r      <= 1'b0;
            running_r  <= 1'b0;
            inc_done_r <= 1'b0;
        end else if (match_s) begin
            state_r    <= ST_DONE;
            fin_r      <= 1'b1;
            running_r  <= 1'b0;
            inc_done_r <= 1'b0;
        end else if (stop) begin
            state_r    <= (state_r == ST_RUN) ? ST_PAUSE : state_r;
            fin_r      <= 1'b0;
            running_r  <= 1'b0;
            inc_done_r <= 1'b0;
        end else if (start_ok_s) begin
            state_r    <= ST_RUN;
            presc_r    <= '0;
            fin_r      <= 1'b0;
            running_r  <= 1'b1;
            inc_done_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            presc_r    <= tick_s ? '0 : presc_r + PW'(1);
            fin_r      <= 1'b0;
            running_r  <= 1'b1;
            inc_done_r <= tick_s;
        end else begin
            fin_r      <= 1'b0;
            running_r  <= 1'b0;
            inc_done_r <= 1'b0;
        end
    end

    assign e_hu_lim_s = (e_ht_s == LIM_HTENS) ? LIM_HUNITS_TOP : LIM_UNITS;

    bcd_mod_counter u_s_units (.CLK(CLK), .rst(rst), .clr(clear), .inc(tick_s), .dec(1'b0),
                               .limit(LIM_UNITS), .q(e_su_s), .carry(c_su_s));
    bcd_mod_counter u_s_tens  (.CLK(CLK), .rst(rst), .clr(clear), .inc(c_su_s), .dec(1'b0),
                               .limit(LIM_TENS), .q(e_st_s), .carry(c_st_s));
    bcd_mod_counter u_m_units (.CLK(CLK), .rst(rst), .clr(clear), .inc(c_st_s), .dec(1'b0),
                               .limit(LIM_UNITS), .q(e_mu_s), .carry(c_mu_s));
    bcd_mod_counter u_m_tens  (.CLK(CLK), .rst(rst), .clr(clear), .inc(c_mu_s), .dec(1'b0),
                               .limit(LIM_TENS), .q(e_mt_s), .carry(c_mt_s));
    bcd_mod_counter u_h_units (.CLK(CLK), .rst(rst), .clr(clear), .inc(c_mt_s), .dec(1'b0),
                               .limit(e_hu_lim_s), .q(e_hu_s), .carry(c_hu_s));
    bcd_mod_counter u_h_tens  (.CLK(CLK), .rst(rst), .clr(clear), .inc(c_hu_s), .dec(1'b0),
                               .limit(LIM_HTENS), .q(e_ht_s), .carry(ht_carry_unused_s));

    assign edit_en_s    = prog_en && (inc ^ dec) && ((state_r == ST_IDLE) || (state_r == ST_PAUSE));
    assign tgt_hu_lim_s = (tgt_ht_r == LIM_HTENS) ? LIM_HUNITS_TOP : LIM_UNITS;

    // Select the target digit under the cursor together with its wrap limit.
    always_comb begin
        sel_val_s = 4'd0;
        sel_lim_s = LIM_UNITS;
        case (dir_cursor)
            CUR_H_TENS:  begin sel_val_s = tgt_ht_r; sel_lim_s = LIM_HTENS;    end
            CUR_H_UNITS: begin sel_val_s = tgt_hu_r; sel_lim_s = tgt_hu_lim_s; end
            CUR_M_TENS:  begin sel_val_s = tgt_mt_r; sel_lim_s = LIM_TENS;     end
            CUR_M_UNITS: begin sel_val_s = tgt_mu_r; sel_lim_s = LIM_UNITS;    end
            CUR_S_TENS:  begin sel_val_s = tgt_st_r; sel_lim_s = LIM_TENS;     end
            CUR_S_UNITS: begin sel_val_s = tgt_su_r; sel_lim_s = LIM_UNITS;    end
            default:     begin sel_val_s = 4'd0;     sel_lim_s = LIM_UNITS;    end
        endcase
    end

    assign edit_nxt_s = bcd_step(sel_val_s, sel_lim_s, inc);

    // Target registers; moving hour tens to 2 clamps hour units so the target stays a legal time.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            tgt_ht_r <= 4'd0;
            tgt_hu_r <= 4'd0;
            tgt_mt_r <= 4'd0;
            tgt_mu_r <= 4'd0;
            tgt_st_r <= 4'd0;
            tgt_su_r <= 4'd0;
        end else if (edit_en_s) begin
            case (dir_cursor)
                CUR_H_TENS: begin
                    tgt_ht_r <= edit_nxt_s;
                    if ((edit_nxt_s == LIM_HTENS) && (tgt_hu_r > LIM_HUNITS_TOP)) begin
                        tgt_hu_r <= LIM_HUNITS_TOP;
                    end else begin
                        tgt_hu_r <= tgt_hu_r;
                    end
                end
                CUR_H_UNITS: tgt_hu_r <= edit_nxt_s;
                CUR_M_TENS:  tgt_mt_r <= edit_nxt_s;
                CUR_M_UNITS: tgt_mu_r <= edit_nxt_s;
                CUR_S_TENS:  tgt_st_r <= edit_nxt_s;
                CUR_S_UNITS: tgt_su_r <= edit_nxt_s;
                default:     tgt_ht_r <= tgt_ht_r;
            endcase
        end else begin
            tgt_ht_r <= tgt_ht_r;
        end
    end

    assign hcrono     = {e_ht_s, e_hu_s};
    assign mcrono     = {e_mt_s, e_mu_s};
    assign scrono     = {e_st_s, e_su_s};
    assign hcrono_fin = {tgt_ht_r, tgt_hu_r};
    assign mcrono_fin = {tgt_mt_r, tgt_mu_r};
    assign scrono_fin = {tgt_st_r, tgt_su_r};
    assign fin_crono  = fin_r;
    assign running    = running_r;

endmodule

// File: tb/tb_crono_timer.sv
// Scoreboard bench for crono_timer (TICKS=4): a seconds-count reference model pushes the
// expected outputs each cycle and a monitor pops and compares them one edge later.
module tb_crono_timer;

    localparam int TK = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, prog_en = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [2:0] dir_cursor = 3'd0;
    logic [7:0] hcrono, mcrono, scrono, hcrono_fin, mcrono_fin, scrono_fin;
    logic       fin_crono, running;

    crono_timer #(.TICKS(TK)) dut (
        .CLK(CLK), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .prog_en(prog_en), .dir_cursor(dir_cursor), .inc(inc), .dec(dec),
        .hcrono(hcrono), .mcrono(mcrono), .scrono(scrono),
        .hcrono_fin(hcrono_fin), .mcrono_fin(mcrono_fin), .scrono_fin(scrono_fin),
        .fin_crono(fin_crono), .running(running)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] h, m, s, hf, mf, sf;
        logic       fin, run;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: elapsed time as a plain seconds count, target as six decimal digits.
    int m_state, m_secs, m_presc;
    int m_tgt[1:6];
    bit m_pending, m_fin;
    logic [3:0] p_ht, p_hu, p_mt, p_mu, p_st, p_su;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int tgt_secs();
        return (m_tgt[1] * 10 + m_tgt[2]) * 3600 + (m_tgt[3] * 10 + m_tgt[4]) * 60 + m_tgt[5] * 10 + m_tgt[6];
    endfunction

    function automatic int lim(input int cur);
        case (cur)
            1:       return 2;
            2:       return (m_tgt[1] == 2) ? 3 : 9;
            3, 5:    return 5;
            default: return 9;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_secs = 0; m_presc = 0; m_pending = 1'b0; m_fin = 1'b0;
        for (int k = 1; k <= 6; k++) m_tgt[k] = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.h   = to_bcd(m_secs / 3600);
        e.m   = to_bcd((m_secs / 60) % 60);
        e.s   = to_bcd(m_secs % 60);
        e.hf  = {4'(m_tgt[1]), 4'(m_tgt[2])};
        e.mf  = {4'(m_tgt[3]), 4'(m_tgt[4])};
        e.sf  = {4'(m_tgt[5]), 4'(m_tgt[6])};
        e.fin = m_fin;
        e.run = (m_state == M_RUN);
        exp_q.push_back(e);
    endtask

    task automatic model_step(input bit s, st, cl, pe, input int cur, input bit i, d);
        int old_t, v, l;
        old_t = tgt_secs();
        if (pe && (m_state == M_IDLE || m_state == M_PAUSE) && (i != d) && cur >= 1 && cur <= 6) begin
            v = m_tgt[cur];
            l = lim(cur);
            if (i) v = (v >= l) ? 0 : v + 1;
            else   v = (v == 0) ? l : v - 1;
            m_tgt[cur] = v;
            if (cur == 1 && v == 2 && m_tgt[2] > 3) m_tgt[2] = 3;
        end
        m_fin = 1'b0;
        if (cl) begin
            m_state = M_IDLE; m_secs = 0; m_presc = 0; m_pending = 1'b0;
        end else if (m_pending && m_state == M_RUN && m_secs == old_t) begin
            m_state = M_DONE; m_fin = 1'b1; m_pending = 1'b0;
        end else if (st) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
            m_pending = 1'b0;
        end else if (s && ((m_state == M_IDLE && old_t != 0) || m_state == M_PAUSE)) begin
            m_state = M_RUN; m_presc = 0; m_pending = 1'b0;
        end else if (m_state == M_RUN) begin
            m_presc++;
            m_pending = 1'b0;
            if (m_presc == TK) begin
                m_presc = 0;
                m_secs = (m_secs + 1) % 86400;
                m_pending = 1'b1;
            end
        end else begin
            m_pending = 1'b0;
        end
    endtask

    // One stimulus cycle, entered and left on a falling edge.
    task automatic cyc(input logic s, st, cl, pe, input logic [2:0] cur, input logic i, d);
        start = s; stop = st; clear = cl; prog_en = pe; dir_cursor = cur; inc = i; dec = d;
        model_step(s, st, cl, pe, int'(cur), i, d);
        push_exp();
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic prog(input logic [2:0] cur, input int n, input logic up);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b1, cur, up, !up);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_now_hcrono", hcrono, 8'h00);
        chk("rst_now_mcrono", mcrono, 8'h00);
        chk("rst_now_scrono", scrono, 8'h00);
        chk("rst_now_hfin", hcrono_fin, 8'h00);
        chk("rst_now_mfin", mcrono_fin, 8'h00);
        chk("rst_now_sfin", scrono_fin, 8'h00);
        chk("rst_now_fin", {7'd0, fin_crono}, 8'h00);
        chk("rst_now_running", {7'd0, running}, 8'h00);
        start = 1'b0; stop = 1'b0; clear = 1'b0; prog_en = 1'b0; inc = 1'b0; dec = 1'b0;
        push_exp();
        @(negedge CLK);
        rst = 1'b1;
    endtask

    // Overwrite the elapsed digits in place; the digit registers keep the value once released.
    task preload(input logic [3:0] a, b, c, d, e, f, input int secs);
        p_ht = a; p_hu = b; p_mt = c; p_mu = d; p_st = e; p_su = f;
        force dut.u_h_tens.q_r  = p_ht;
        force dut.u_h_units.q_r = p_hu;
        force dut.u_m_tens.q_r  = p_mt;
        force dut.u_m_units.q_r = p_mu;
        force dut.u_s_tens.q_r  = p_st;
        force dut.u_s_units.q_r = p_su;
        m_secs = secs;
        idle(1);
        release dut.u_h_tens.q_r;
        release dut.u_h_units.q_r;
        release dut.u_m_tens.q_r;
        release dut.u_m_units.q_r;
        release dut.u_s_tens.q_r;
        release dut.u_s_units.q_r;
    endtask

    // Monitor: pop the expectation for this edge and compare every output.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hcrono", hcrono, e.h);
            chk("mcrono", mcrono, e.m);
            chk("scrono", scrono, e.s);
            chk("hcrono_fin", hcrono_fin, e.hf);
            chk("mcrono_fin", mcrono_fin, e.mf);
            chk("scrono_fin", scrono_fin, e.sf);
            chk("fin_crono", {7'd0, fin_crono}, {7'd0, e.fin});
            chk("running", {7'd0, running}, {7'd0, e.run});
        end
    end

    initial begin
        model_reset();
        @(negedge CLK);
        reset_pulse();
        idle(2);

        // Start with a zero target is ignored.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(4);

        // Target 00:00:03: ticks at 4, 8, 12, fin at 13, then DONE ignores start.
        prog(3'd6, 3, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(16);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(6);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Stop on the tick cycle suppresses the increment; restart re-arms the prescaler.
        prog(3'd5, 1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(12);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        prog(3'd4, 2, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Hour digit wrap and clamp rules; inc with dec together does nothing.
        prog(3'd1, 2, 1'b1);
        prog(3'd2, 5, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
        prog(3'd1, 1, 1'b1);
        prog(3'd2, 2, 1'b0);
        prog(3'd1, 2, 1'b1);
        prog(3'd1, 1, 1'b0);
        prog(3'd7, 2, 1'b1);

        // Carry from 00:00:59 toward target 00:02:00, then full-day wrap.
        reset_pulse();
        prog(3'd4, 2, 1'b1);
        preload(4'd0, 4'd0, 4'd0, 4'd0, 4'd5, 4'd9, 59);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(250);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        preload(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 86399);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(6);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // Reset mid-run at 00:00:02 abandons the count for good.
        prog(3'd6, 5, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(8);
        reset_pulse();
        idle(30);

        // Clear beats start while running.
        prog(3'd6, 3, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_pulse();
            end else begin
                cyc($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
                    3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
            end
        end
        idle(2);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
